ppi_bus_initiator: RTL

PPI_BUS_INITIATOR -- requirements
Module: ppi_bus_initiator

---
 rtl/ppi_bus_pkg.sv | 15 +
 rtl/ppi_bus_initiator_ack_timer.sv | 22 ++
 rtl/ppi_bus_initiator.sv | 115 +++++++++++
 3 files changed

// File: rtl/ppi_bus_pkg.sv
// Shared types and register addresses for the PPI bus initiator.
// State encoding and peripheral register map live here so the bench and RTL agree.
package ppi_bus_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [1:0] PORT_A  = 2'b00;
    localparam logic [1:0] PORT_B  = 2'b01;
    localparam logic [1:0] PORT_C  = 2'b10;
    localparam logic [1:0] CONTROL = 2'b11;
endpackage

// File: rtl/ppi_bus_initiator_ack_timer.sv
// ASSERT-phase watchdog: counts cycles since select and flags the last allowed one.
// Built only when PPI_INIT_TIMEOUT_EN is defined.
module ppi_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 8'd1;
    end

    // Edge that closes the ACK_TIMEOUT-th ASSERT cycle.
    assign expired = enable && (count == 8'(ACK_TIMEOUT - 1));
endmodule

// File: rtl/ppi_bus_initiator.sv
// Host-to-PPI bus initiator: one strobed access per request, with release and idle gap.
// Optional ack watchdog enabled by defining PPI_INIT_TIMEOUT_EN.
module ppi_bus_initiator
    import ppi_bus_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int IDLE_GAP    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_address,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       chip_select,
    output logic       read_enable,
    output logic       write_enable,
    output logic [1:0] address,
    output logic [7:0] data_bus_out,
    input  logic [7:0] data_bus_in,
    input  logic       ack
);
    state_t     state, state_next;
    logic [3:0] gap_count;
    logic       lat_write;
    logic       expired;
    logic       accept;
    logic       complete;

    assign accept   = (state == IDLE) && req_valid && req_ready;
    assign complete = (state == ASSERT) && (ack || expired);

`ifdef PPI_INIT_TIMEOUT_EN
    logic timeout_flag;

    ppi_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (state == ASSERT),
        .expired (expired)
    );

    // Ack on the final count wins, so only a missing ack marks a timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         timeout_flag <= 1'b0;
        else if (complete) timeout_flag <= ~ack;
    end

    assign rsp_timeout = timeout_flag;
`else
    logic [7:0] unused_ack_timeout;
    assign unused_ack_timeout = 8'(ACK_TIMEOUT);
    assign expired     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ASSERT;
            ASSERT:  if (complete) state_next = RELEASE;
            RELEASE: state_next = GAP;
            GAP:     if (gap_count == 4'(IDLE_GAP - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gap_count    <= '0;
            lat_write    <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            chip_select  <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            data_bus_out <= '0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
            rsp_valid <= complete;
            gap_count <= (state == GAP) ? gap_count + 4'd1 : '0;

            if (accept) begin
                lat_write    <= req_write;
                chip_select  <= 1'b1;
                write_enable <= req_write;
                read_enable  <= ~req_write;
                address      <= req_address;
                data_bus_out <= req_write ? req_wdata : 8'h00;
            end

            // Drop the strobe but keep select/address so the peripheral sees a clean falling edge.
            if (complete) begin
                write_enable <= 1'b0;
                read_enable  <= 1'b0;
                rsp_rdata    <= (ack && !lat_write) ? data_bus_in : 8'h00;
            end

            if (state == RELEASE) begin
                chip_select  <= 1'b0;
                address      <= '0;
                data_bus_out <= '0;
            end
        end
    end
endmodule
